// File: rtl/vector_packer_pkg.sv
// Shared definitions for the vector packer and the downstream parallel adder tree.
// Fixes the vector geometry (NUM_WORDS x WORD_W), the adder-tree sum width and the
// types used on the packer/adder boundary.
package vector_packer_pkg;

  localparam int unsigned NUM_WORDS = 256;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam int unsigned COUNT_W   = $clog2(NUM_WORDS + 1);
  localparam int unsigned SUM_W     = WORD_W + $clog2(NUM_WORDS);

  typedef logic [WORD_W-1:0]      word_t;
  typedef word_t [NUM_WORDS-1:0]  vector_t;
  typedef logic [COUNT_W-1:0]     count_t;
  typedef logic [IDX_W-1:0]       idx_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // True when slot k lies inside a vector holding cnt real words.
  function automatic logic word_in_range(input int unsigned k, input count_t cnt);
    return k < 32'(cnt);
  endfunction

endpackage

// File: rtl/vector_packer.sv
// Stream-to-vector packer feeding the parallel adder tree.
// Accepts one word per cycle on a valid/ready stream, assembles NUM_WORDS words (or
// fewer when in_last closes the vector early) and presents the vector on a registered
// valid/ready output. Slots beyond out_count always read as zero.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_data/in_valid    input word stream
//   in_last             closes the current vector (qualified by the handshake)
//   in_ready            packer accepts a word this cycle
//   out_data/out_count  packed vector and its number of real words
//   out_valid/out_ready vector handshake
module vector_packer
  import vector_packer_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  word_t   in_data,
  input  logic    in_valid,
  input  logic    in_last,
  output logic    in_ready,
  output vector_t out_data,
  output logic    out_valid,
  input  logic    out_ready,
  output count_t  out_count
);

  state_e  state_q, state_d;
  idx_t    wr_idx_q, wr_idx_d;
  count_t  hold_cnt_q, hold_cnt_d;
  logic    in_ready_q, in_ready_d;
  logic    out_valid_q, out_valid_d;
  vector_t out_data_q, out_data_d;
  count_t  out_count_q, out_count_d;

  word_t   buf_q [NUM_WORDS];

  logic    accept;
  logic    complete;
  logic    out_free;
  logic    load;
  logic    bypass;
  count_t  fill_cnt;
  count_t  load_cnt;

  // Handshake qualifiers
  always_comb begin
    accept   = in_valid && in_ready_q;
    complete = accept && (in_last || (wr_idx_q == idx_t'(NUM_WORDS - 1)));
    out_free = !out_valid_q || out_ready;
    fill_cnt = count_t'(wr_idx_q) + count_t'(1);
  end

  // FILL/HOLD control and write-index bookkeeping
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    hold_cnt_d = hold_cnt_q;
    load       = 1'b0;
    bypass     = 1'b0;
    load_cnt   = hold_cnt_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (complete) begin
            wr_idx_d = '0;
            if (out_free) begin
              // Completing word goes straight to the output register.
              load     = 1'b1;
              bypass   = 1'b1;
              load_cnt = fill_cnt;
            end else begin
              state_d    = ST_HOLD;
              hold_cnt_d = fill_cnt;
            end
          end else begin
            wr_idx_d = wr_idx_q + idx_t'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    in_ready_d = (state_d == ST_FILL);
  end

  // Output register next state; unfilled slots are forced to zero on every load
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_count_d = load_cnt;
      for (int unsigned k = 0; k < NUM_WORDS; k++) begin
        if (!word_in_range(k, load_cnt)) begin
          out_data_d[idx_t'(k)] = '0;
        end else if (bypass && (idx_t'(k) == wr_idx_q)) begin
          out_data_d[idx_t'(k)] = in_data;
        end else begin
          out_data_d[idx_t'(k)] = buf_q[idx_t'(k)];
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_idx_q    <= '0;
      hold_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  // Assembly buffer; stale contents are masked by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[wr_idx_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule
